mem_io_bridge: RTL

//  Parametrised memory/IO bridge between the CPU datapath and data memory plus N_CH IO peripherals.

---
 rtl/mem_io_pkg.sv | 18 +
 rtl/io_addr_decode.sv | 25 ++
 rtl/mem_io_bridge.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// Shared types and helpers for the memory/IO bridge: FSM encoding, default
// IO window base and the channel-index width helper.
package mem_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFFFC00;

    // Keeps index vectors at least one bit wide when only one channel exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_addr_decode.sv
// Combinational IO window decode: address -> channel index and mapped flag.
module io_addr_decode
    import mem_io_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                N_CH           = 4,
    parameter logic [DATA_W-1:0] BASE_ADDR      = DEF_BASE_ADDR[DATA_W-1:0],
    parameter int                CH_STRIDE_LOG2 = 4,
    parameter int                IDX_W          = idx_w(N_CH)
) (
    input  logic [DATA_W-1:0] addr_i,
    output logic              mapped_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [DATA_W-1:0] off;
    logic [DATA_W-1:0] idx_full;

    assign off      = addr_i - BASE_ADDR;
    assign idx_full = off >> CH_STRIDE_LOG2;
    // The lower bound guards against addresses that wrap below the window.
    assign mapped_o = (addr_i >= BASE_ADDR) && (idx_full < DATA_W'(N_CH));
    assign idx_o    = idx_full[IDX_W-1:0];

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-side bridge: zero-latency memory pass-through plus a registered IO
// access engine with per-channel ready handshake, CPU stall and timeout.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                IO_W           = 16,
    parameter int                N_CH           = 4,
    parameter logic [DATA_W-1:0] BASE_ADDR      = DEF_BASE_ADDR[DATA_W-1:0],
    parameter int                CH_STRIDE_LOG2 = 4,
    parameter int                TIMEOUT        = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 m_read,
    input  logic                 m_write,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic [DATA_W-1:0]    addr_in,
    input  logic [DATA_W-1:0]    r_rdata,
    input  logic [DATA_W-1:0]    m_rdata,
    output logic [DATA_W-1:0]    addr_out,
    output logic [DATA_W-1:0]    write_data,
    output logic [DATA_W-1:0]    r_wdata,
    output logic                 stall,
    output logic [N_CH-1:0]      ch_sel,
    output logic                 ch_wr,
    output logic                 ch_rd,
    output logic [IO_W-1:0]      ch_wdata,
    input  logic [N_CH*IO_W-1:0] ch_rdata,
    input  logic [N_CH-1:0]      ch_ready,
    output logic                 bus_err
);

    localparam int IDX_W = idx_w(N_CH);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_CH-1:0]   sel_q, sel_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [IO_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]       tcnt_q, tcnt_d;
    logic              err_q, err_d;

    logic              mapped;
    logic [IDX_W-1:0]  dec_idx;

    io_addr_decode #(
        .DATA_W         (DATA_W),
        .N_CH           (N_CH),
        .BASE_ADDR      (BASE_ADDR),
        .CH_STRIDE_LOG2 (CH_STRIDE_LOG2),
        .IDX_W          (IDX_W)
    ) u_dec (
        .addr_i   (addr_in),
        .mapped_o (mapped),
        .idx_o    (dec_idx)
    );

    assign addr_out   = addr_in;
    assign write_data = m_write ? r_rdata : '0;
    assign r_wdata    = m_read ? m_rdata : rdata_q;
    assign ch_sel     = sel_q;
    assign ch_rd      = rd_q;
    assign ch_wr      = wr_q;
    assign ch_wdata   = wdata_q;
    assign bus_err    = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tcnt_d  = tcnt_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_read || io_write) begin
                    stall = 1'b1;
                    if (mapped) begin
                        idx_d          = dec_idx;
                        sel_d          = '0;
                        sel_d[dec_idx] = 1'b1;
                        rd_d           = io_read;
                        wr_d           = ~io_read;
                        wdata_d        = r_rdata[IO_W-1:0];
                        tcnt_d         = '0;
                        state_d        = ST_WAIT;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (ch_ready[idx_q]) begin
                    if (rd_q) rdata_d = DATA_W'(ch_rdata[idx_q*IO_W +: IO_W]);
                    sel_d   = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_DONE;
                end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Nothing can start while reset is held, so the hold request must drop with it.
        if (reset) stall = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

endmodule
